// File: rtl/rv_decode_execute_if.sv
// Bundle between the issue logic and the RV32I decode/execute stage:
// decode inputs and the registered control/ALU outputs.
interface rv_decode_execute_if #(
   parameter int XLEN = 32
);
   logic            en;
   logic [31:0]     instruction;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [11:0]     control;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7_5;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] alu_result;
   logic [3:0]      alu_status;
   logic            illegal;

   modport master (
      output en, instruction, alu_a, alu_b,
      input  control, opcode, funct3, funct7_5,
      input  rs1, rs2, rd, alu_op,
      input  alu_result, alu_status, illegal
   );

   modport slave (
      input  en, instruction, alu_a, alu_b,
      output control, opcode, funct3, funct7_5,
      output rs1, rs2, rd, alu_op,
      output alu_result, alu_status, illegal
   );
endinterface

// File: rtl/rv_decode_execute.sv
// Single-cycle RV32I decode/execute stage: decodes the instruction,
// runs the ALU on pre-muxed operands and registers everything.
module rv_decode_execute #(
   parameter int XLEN = 32
) (
   input logic clk,
   input logic rst_n,
   rv_decode_execute_if.slave bus
);

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic            f75;
   logic [11:0]     ctrl;
   logic            ill;
   logic [1:0]      alu_ctrl;
   logic [3:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN:0]   add_w;
   logic [XLEN:0]   sub_w;
   logic            v_add;
   logic            v_sub;
   logic [XLEN-1:0] res;
   logic            c_f;
   logic            v_f;

   logic [11:0]     control_d, control_q;
   logic [6:0]      opcode_d, opcode_q;
   logic [2:0]      funct3_d, funct3_q;
   logic            funct7_5_d, funct7_5_q;
   logic [4:0]      rs1_d, rs1_q;
   logic [4:0]      rs2_d, rs2_q;
   logic [4:0]      rd_d, rd_q;
   logic [3:0]      alu_op_d, alu_op_q;
   logic [XLEN-1:0] alu_result_d, alu_result_q;
   logic [3:0]      alu_status_d, alu_status_q;
   logic            illegal_d, illegal_q;

   assign opc      = bus.instruction[6:0];
   assign f3       = bus.instruction[14:12];
   assign f75      = bus.instruction[30];
   assign a        = bus.alu_a;
   assign b        = bus.alu_b;
   assign alu_ctrl = ctrl[2:1];

   always_comb begin
      ctrl = 12'h000;
      ill  = 1'b0;
      unique case (opc)
         7'b0110011: ctrl = 12'h045;
         7'b0010011: ctrl = 12'h147;
         7'b0000011: ctrl = 12'h149;
         7'b0100011: ctrl = 12'h181;
         7'b1100011: ctrl = 12'h403;
         7'b1101111: ctrl = 12'h851;
         7'b1100111: ctrl = 12'h971;
         7'b0110111: ctrl = 12'h059;
         7'b0010111: ctrl = 12'h241;
         default:    ill  = 1'b1;
      endcase
   end

   // Only shifts-right take funct7_5 from an I-type, so ADDI stays ADD.
   always_comb begin
      op = 4'b0000;
      unique case (alu_ctrl)
         2'b00: op = 4'b0000;
         2'b01: op = 4'b1000;
         2'b10: op = {f75, f3};
         2'b11: op = {(f3 == 3'b101) & f75, f3};
      endcase
   end

   assign add_w = {1'b0, a} + {1'b0, b};
   assign sub_w = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
   assign v_add = (a[XLEN-1] == b[XLEN-1])
                & (add_w[XLEN-1] != a[XLEN-1]);
   assign v_sub = (a[XLEN-1] != b[XLEN-1])
                & (sub_w[XLEN-1] != a[XLEN-1]);

   always_comb begin
      res = add_w[XLEN-1:0];
      c_f = add_w[XLEN];
      v_f = v_add;
      unique case (op)
         4'b1000: begin
            res = sub_w[XLEN-1:0];
            c_f = sub_w[XLEN];
            v_f = v_sub;
         end
         4'b0010: begin
            res = {{(XLEN-1){1'b0}}, sub_w[XLEN-1] ^ v_sub};
            c_f = sub_w[XLEN];
            v_f = v_sub;
         end
         4'b0011: begin
            res = {{(XLEN-1){1'b0}}, ~sub_w[XLEN]};
            c_f = sub_w[XLEN];
            v_f = v_sub;
         end
         4'b0001: begin
            res = a << b[4:0];
            c_f = 1'b0;
            v_f = 1'b0;
         end
         4'b0100: begin
            res = a ^ b;
            c_f = 1'b0;
            v_f = 1'b0;
         end
         4'b0101: begin
            res = a >> b[4:0];
            c_f = 1'b0;
            v_f = 1'b0;
         end
         4'b1101: begin
            res = $unsigned($signed(a) >>> b[4:0]);
            c_f = 1'b0;
            v_f = 1'b0;
         end
         4'b0110: begin
            res = a | b;
            c_f = 1'b0;
            v_f = 1'b0;
         end
         4'b0111: begin
            res = a & b;
            c_f = 1'b0;
            v_f = 1'b0;
         end
         default: begin
            res = add_w[XLEN-1:0];
            c_f = add_w[XLEN];
            v_f = v_add;
         end
      endcase
   end

   always_comb begin
      control_d    = control_q;
      opcode_d     = opcode_q;
      funct3_d     = funct3_q;
      funct7_5_d   = funct7_5_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rd_d         = rd_q;
      alu_op_d     = alu_op_q;
      alu_result_d = alu_result_q;
      alu_status_d = alu_status_q;
      illegal_d    = illegal_q;
      if (bus.en) begin
         control_d    = ctrl;
         opcode_d     = opc;
         funct3_d     = f3;
         funct7_5_d   = f75;
         rs1_d        = bus.instruction[19:15];
         rs2_d        = bus.instruction[24:20];
         rd_d         = bus.instruction[11:7];
         alu_op_d     = op;
         alu_result_d = res;
         alu_status_d = {res[XLEN-1], res == '0, c_f, v_f};
         illegal_d    = ill;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         control_q    <= '0;
         opcode_q     <= '0;
         funct3_q     <= '0;
         funct7_5_q   <= 1'b0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         alu_op_q     <= '0;
         alu_result_q <= '0;
         alu_status_q <= '0;
         illegal_q    <= 1'b0;
      end else begin
         control_q    <= control_d;
         opcode_q     <= opcode_d;
         funct3_q     <= funct3_d;
         funct7_5_q   <= funct7_5_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         alu_op_q     <= alu_op_d;
         alu_result_q <= alu_result_d;
         alu_status_q <= alu_status_d;
         illegal_q    <= illegal_d;
      end
   end

   assign bus.control    = control_q;
   assign bus.opcode     = opcode_q;
   assign bus.funct3     = funct3_q;
   assign bus.funct7_5   = funct7_5_q;
   assign bus.rs1        = rs1_q;
   assign bus.rs2        = rs2_q;
   assign bus.rd         = rd_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.alu_result = alu_result_q;
   assign bus.alu_status = alu_status_q;
   assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_rv_decode_execute.sv
// Bench for rv_decode_execute: instruction-level model compared every
// cycle, plus directed vectors with hand-computed results.
module tb_rv_decode_execute;

   typedef struct packed {
      logic [11:0] control;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        funct7_5;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic [31:0] result;
      logic [3:0]  status;
      logic        illegal;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t exp_q;

   rv_decode_execute_if bus ();

   rv_decode_execute dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic sovf(input longint s);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   // Expected outputs from the ISA meaning of the instruction.
   function automatic exp_t model(input logic [31:0] ins,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t   e;
      longint sa, sb, ua, ub;
      logic   c, v;
      logic signed [31:0] sra;
      e = '0;
      e.opcode   = ins[6:0];
      e.funct3   = ins[14:12];
      e.funct7_5 = ins[30];
      e.rs1      = ins[19:15];
      e.rs2      = ins[24:20];
      e.rd       = ins[11:7];
      case (ins[6:0])
         7'h33:   e.control = 12'h045;
         7'h13:   e.control = 12'h147;
         7'h03:   e.control = 12'h149;
         7'h23:   e.control = 12'h181;
         7'h63:   e.control = 12'h403;
         7'h6F:   e.control = 12'h851;
         7'h67:   e.control = 12'h971;
         7'h37:   e.control = 12'h059;
         7'h17:   e.control = 12'h241;
         default: e.illegal = 1'b1;
      endcase
      if (ins[6:0] == 7'h33)
         e.alu_op = {ins[30], ins[14:12]};
      else if (ins[6:0] == 7'h13)
         e.alu_op = {ins[14:12] == 3'd5 && ins[30], ins[14:12]};
      else if (ins[6:0] == 7'h63)
         e.alu_op = 4'b1000;
      else
         e.alu_op = 4'b0000;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      c = 1'b0;
      v = 1'b0;
      case (e.alu_op)
         4'b1000, 4'b0010, 4'b0011: begin
            c = (a >= b);
            v = sovf(sa - sb);
            if (e.alu_op == 4'b1000) e.result = a - b;
            else if (e.alu_op == 4'b0010) e.result = {31'd0, sa < sb};
            else e.result = {31'd0, a < b};
         end
         4'b0001: e.result = a << b[4:0];
         4'b0100: e.result = a ^ b;
         4'b0101: e.result = a >> b[4:0];
         4'b1101: begin
            sra = $signed(a) >>> b[4:0];
            e.result = sra;
         end
         4'b0110: e.result = a | b;
         4'b0111: e.result = a & b;
         default: begin
            e.result = a + b;
            c = (ua + ub) > 64'd4294967295;
            v = sovf(sa + sb);
         end
      endcase
      e.status = {e.result[31], e.result == 32'd0, c, v};
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_q <= '0;
      else if (bus.en)
         exp_q <= model(bus.instruction, bus.alu_a, bus.alu_b);
   end

   always @(posedge clk) begin
      #2;
      chk("control", {20'd0, bus.control}, {20'd0, exp_q.control});
      chk("opcode", {25'd0, bus.opcode}, {25'd0, exp_q.opcode});
      chk("funct3", {29'd0, bus.funct3}, {29'd0, exp_q.funct3});
      chk("funct7_5", {31'd0, bus.funct7_5}, {31'd0, exp_q.funct7_5});
      chk("rs1", {27'd0, bus.rs1}, {27'd0, exp_q.rs1});
      chk("rs2", {27'd0, bus.rs2}, {27'd0, exp_q.rs2});
      chk("rd", {27'd0, bus.rd}, {27'd0, exp_q.rd});
      chk("alu_op", {28'd0, bus.alu_op}, {28'd0, exp_q.alu_op});
      chk("alu_result", bus.alu_result, exp_q.result);
      chk("alu_status", {28'd0, bus.alu_status}, {28'd0, exp_q.status});
      chk("illegal", {31'd0, bus.illegal}, {31'd0, exp_q.illegal});
   end

   task automatic step(input logic e, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.en          = e;
      bus.instruction = ins;
      bus.alu_a       = a;
      bus.alu_b       = b;
      @(posedge clk);
      #3;
   endtask

   logic [31:0] v_ins [13];
   logic [31:0] v_a   [13];
   logic [31:0] v_b   [13];
   logic [31:0] v_ctl [13];
   logic [31:0] v_res [13];
   logic [31:0] v_st  [13];

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.instruction = 32'd0;
      bus.alu_a = 32'd0;
      bus.alu_b = 32'd0;

      v_ins = '{32'h0020A1B3, 32'h0020B1B3, 32'h0020C1B3, 32'h002091B3,
                32'h0020D1B3, 32'h0020F1B3, 32'h0020E1B3, 32'h00208063,
                32'h000010B7, 32'h0000006F, 32'h00002083, 32'h00000097,
                32'h402091B3};
      v_a   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h00000001,
                32'h80000000, 32'h0000000C, 32'h0000000C, 32'h00000003,
                32'h00000000, 32'h00000010, 32'h00000100, 32'h00001000,
                32'h00000004};
      v_b   = '{32'h00000001, 32'h00000001, 32'hFF00FF00, 32'h00000021,
                32'h0000001F, 32'h0000000A, 32'h0000000A, 32'h00000005,
                32'h00001000, 32'h00000004, 32'h00000008, 32'h00000020,
                32'h00000005};
      v_ctl = '{32'h045, 32'h045, 32'h045, 32'h045, 32'h045, 32'h045,
                32'h045, 32'h403, 32'h059, 32'h851, 32'h149, 32'h241,
                32'h045};
      v_res = '{32'h00000001, 32'h00000000, 32'h0FF00FF0, 32'h00000002,
                32'h00000001, 32'h00000008, 32'h0000000E, 32'hFFFFFFFE,
                32'h00001000, 32'h00000014, 32'h00000108, 32'h00001020,
                32'h00000009};
      v_st  = '{32'h2, 32'h6, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

      repeat (2) @(negedge clk);
      chk("reset_control", {20'd0, bus.control}, 32'h0);
      chk("reset_result", bus.alu_result, 32'h0);
      rst_n = 1'b1;

      step(1'b1, 32'h001101B3, 32'h20, 32'h3);
      chk("add_control", {20'd0, bus.control}, 32'h045);
      chk("add_op", {28'd0, bus.alu_op}, 32'h0);
      chk("add_result", bus.alu_result, 32'h23);
      chk("add_status", {28'd0, bus.alu_status}, 32'h0);
      chk("add_rs1", {27'd0, bus.rs1}, 32'd2);
      chk("add_rs2", {27'd0, bus.rs2}, 32'd1);
      chk("add_rd", {27'd0, bus.rd}, 32'd3);
      chk("add_illegal", {31'd0, bus.illegal}, 32'd0);

      step(1'b1, 32'h40208033, 32'h5, 32'h5);
      chk("sub_op", {28'd0, bus.alu_op}, 32'h8);
      chk("sub_result", bus.alu_result, 32'h0);
      chk("sub_status", {28'd0, bus.alu_status}, 32'h6);

      step(1'b1, 32'h001101B3, 32'h7FFFFFFF, 32'h1);
      chk("ovf_result", bus.alu_result, 32'h80000000);
      chk("ovf_status", {28'd0, bus.alu_status}, 32'h9);

      step(1'b1, 32'h4010D093, 32'h80000000, 32'h4);
      chk("srai_control", {20'd0, bus.control}, 32'h147);
      chk("srai_op", {28'd0, bus.alu_op}, 32'hD);
      chk("srai_result", bus.alu_result, 32'hF8000000);

      step(1'b1, 32'h40008093, 32'hA, 32'hFFFFFFFF);
      chk("addi_op", {28'd0, bus.alu_op}, 32'h0);
      chk("addi_result", bus.alu_result, 32'h9);
      chk("addi_status", {28'd0, bus.alu_status}, 32'h2);

      step(1'b0, 32'h0000007F, 32'h1234, 32'h1);
      chk("hold_result", bus.alu_result, 32'h9);
      chk("hold_illegal", {31'd0, bus.illegal}, 32'd0);

      step(1'b1, 32'h0000007F, 32'h1234, 32'h1);
      chk("ill_control", {20'd0, bus.control}, 32'h0);
      chk("ill_flag", {31'd0, bus.illegal}, 32'd1);
      chk("ill_result", bus.alu_result, 32'h1235);

      step(1'b1, 32'h00112023, 32'h100, 32'h4);
      chk("store_control", {20'd0, bus.control}, 32'h181);
      step(1'b1, 32'h000080E7, 32'h200, 32'h8);
      chk("jalr_control", {20'd0, bus.control}, 32'h971);

      for (int i = 0; i < 13; i++) begin
         step(1'b1, v_ins[i], v_a[i], v_b[i]);
         chk($sformatf("vec%0d_control", i),
             {20'd0, bus.control}, v_ctl[i]);
         chk($sformatf("vec%0d_result", i), bus.alu_result, v_res[i]);
         chk($sformatf("vec%0d_status", i),
             {28'd0, bus.alu_status}, v_st[i]);
      end

      @(negedge clk);
      bus.en = 1'b1;
      bus.instruction = 32'h001101B3;
      bus.alu_a = 32'h55;
      bus.alu_b = 32'h1;
      #1 rst_n = 1'b0;
      #1;
      chk("async_control", {20'd0, bus.control}, 32'h0);
      chk("async_result", bus.alu_result, 32'h0);
      chk("async_rs2", {27'd0, bus.rs2}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 32'h001101B3, 32'h55, 32'h1);
      chk("post_reset_result", bus.alu_result, 32'h56);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_decode_execute.md
Name: rv_decode_execute

Overview:
- Single-cycle RV32I decode/execute stage for the minimal superscalar core.
- Decodes a 32-bit instruction into a 12-bit control word, the instruction fields and a 4-bit ALU operation.
- Applies that operation to two pre-muxed 32-bit operands.
- All outputs are registered, so results reach the writeback/memory logic one clock after presentation.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  stage enable; 0 holds every output register
- instruction  in  32  instruction word
- alu_a  in  32  operand A, already muxed upstream
- alu_b  in  32  operand B, already muxed upstream
- control  out  12  registered control word
- opcode  out  7  instruction[6:0]
- funct3  out  3  instruction[14:12]
- funct7_5  out  1  instruction[30]
- rs1  out  5  instruction[19:15]
- rs2  out  5  instruction[24:20]
- rd  out  5  instruction[11:7]
- alu_op  out  4  registered ALU operation
- alu_result  out  32  registered ALU result
- alu_status  out  4  registered flags: [3]N, [2]Z, [1]C, [0]V
- illegal  out  1  unrecognised opcode

Behaviour:
- Reset: rst_n low asynchronously clears every output to 0. Release takes effect at the next rising clk edge.
- Capture and latency:
  - On a rising edge with en=1, all outputs load combinational decode/ALU results of the current inputs.
  - Latency is exactly 1 cycle.
  - With en=0, all outputs hold.
- Control word layout: [11:10] branch, [9:8] alu_src, [7] ram_rw, [6] write_rd, [5] pc_src, [4:3] rd_src, [2:1] alu_ctrl, [0] pc_load.
- Field encodings:
  - branch: 00 none, 01 conditional, 10 unconditional.
  - alu_src: 00 rs2, 01 imm, 10 pc+imm.
  - rd_src: 00 ALU, 01 memory, 10 pc+4, 11 imm.
  - ram_rw: 1 = write.
- Decode by opcode (unlisted control bits are 0):
  - 0110011 R: write_rd=1, alu_ctrl=10, pc_load=1 -> 0x045.
  - 0010011 I-ALU: alu_src=01, write_rd=1, alu_ctrl=11, pc_load=1 -> 0x147.
  - 0000011 load: alu_src=01, write_rd=1, rd_src=01, pc_load=1 -> 0x149.
  - 0100011 store: alu_src=01, ram_rw=1, pc_load=1 -> 0x181.
  - 1100011 branch: branch=01, alu_ctrl=01, pc_load=1 -> 0x403.
  - 1101111 JAL: branch=10, write_rd=1, rd_src=10, pc_load=1 -> 0x851.
  - 1100111 JALR: branch=10, alu_src=01, write_rd=1, pc_src=1, rd_src=10, pc_load=1 -> 0x971.
  - 0110111 LUI: write_rd=1, rd_src=11, pc_load=1 -> 0x059.
  - 0010111 AUIPC: alu_src=10, write_rd=1, pc_load=1 -> 0x241.
  - Any other opcode: control=0x000, illegal=1. The ALU still computes ADD.
- ALU control, from alu_ctrl, funct3 and funct7_5:
  - 00 -> ADD (0000).
  - 01 -> SUB (1000).
  - 10 -> {funct7_5, funct3}.
  - 11 -> {funct3==101 ? funct7_5 : 0, funct3}, so ADDI never becomes SUB.
- ALU operation encodings:
  - ADD 0000, SUB 1000
  - SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, SRA 1101
  - OR 0110, AND 0111
  - Unused codes produce ADD.
- ALU arithmetic:
  - Shifts use alu_b[4:0]; SRA sign-extends.
  - SLT/SLTU results are 0 or 1, zero-extended.
  - All arithmetic wraps mod 2^32.
- Status flags:
  - N = result[31]; Z = (result==0), valid for all ops.
  - ADD: C = carry out of bit 31; V = signed overflow.
  - SUB and SLT/SLTU: computed as a + ~b + 1. C = 1 iff a >= b unsigned; V = signed overflow of the subtraction.
  - Logic and shift ops: C=V=0.

Test Plan:
- Reset: assert rst_n=0 mid-operation with en=1 -> all outputs 0 immediately, without waiting for a clock edge.
- ADD: instruction=0x001101B3, alu_a=0x20, alu_b=0x3 -> after one edge:
  - control=0x045, alu_op=0000, alu_result=0x23, status=0000
  - rs1=2, rs2=1, rd=3, funct3=0, illegal=0.
- SUB to zero: instruction=0x40208033, a=b=5 -> alu_op=1000, result=0, status=0110 (Z=1, C=1).
- ADD overflow: R-type ADD, a=0x7FFFFFFF, b=1 -> result=0x80000000, status=1001.
- Shifts:
  - SRAI: instruction=0x4010D093, a=0x80000000, b=4 -> control=0x147, alu_op=1101, result=0xF8000000.
  - ADDI with instr[30]=1 -> alu_op=0000.
- Hold and illegal:
  - en=0 with new inputs -> outputs unchanged.
  - opcode=1111111 -> control=0, illegal=1.
  - Store opcode -> control=0x181; JALR opcode -> control=0x971.
